instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter INSTR_WIDTH, default 20, sets the instruction word width.
REQ-002 Parameter ADDR_BITS, default 5, sets the instruction-memory address width (32 words).
REQ-003 Parameter COUNT_WIDTH, default 8, sets the retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 load_en  input  1  instruction-memory write strobe.
REQ-007 load_addr  input  ADDR_BITS  write address.
REQ-008 load_data  input  INSTR_WIDTH  write data.
REQ-009 start  input  1  begin execution from address 0.
REQ-010 advance  input  1  downstream control unit has consumed the current instruction.
REQ-011 instr  output  INSTR_WIDTH  registered instruction word fed to the control unit.
REQ-012 pc  output  ADDR_BITS  address of the word currently on instr.
REQ-013 valid  output  1  instr holds a fetched word.
REQ-014 halted  output  1  a halt word (instr[19:18]==2'b00) is being held.
REQ-015 icount  output  COUNT_WIDTH  count of instructions retired via advance.

Function
REQ-016 Internal memory: 2^ADDR_BITS words x INSTR_WIDTH, one synchronous write port and one synchronous read port, not reset.
REQ-017 FSM states: IDLE, FETCH, ISSUE, HALT; encoding free.
REQ-018 IDLE: instr=0, valid=0, halted=0; load_en writes load_data to mem[load_addr] on that edge.
REQ-019 IDLE, start=1 -> FETCH, pc<=0, icount<=0.
REQ-020 load_en and start in the same IDLE cycle: write completes, transition occurs, and the following FETCH reads the newly written word if load_addr==0.
REQ-021 load_en outside IDLE and HALT is ignored; memory is unchanged.
REQ-022 FETCH (one cycle): instr<=mem[pc], valid<=1, -> ISSUE; fetch latency is 2 cycles from start to valid=1.
REQ-023 ISSUE: instr and pc are held stable until advance=1.
REQ-024 ISSUE with instr[19:18]==2'b00 -> HALT next cycle, halted<=1; advance is ignored in this case.
REQ-025 ISSUE with a non-halt word and advance=1:
  - pc<=pc+1 modulo 2^ADDR_BITS (31 wraps to 0);
  - icount<=icount+1, saturating at all-ones;
  - -> FETCH; valid<=0 for the FETCH cycle.
REQ-026 advance in IDLE, FETCH, or HALT is ignored.
REQ-027 HALT: instr, pc, and valid hold their values; halted=1; icount holds; load_en is accepted.
REQ-028 HALT, start=1 -> FETCH, pc<=0, icount<=0, halted<=0.
REQ-029 start in FETCH or ISSUE is ignored.
REQ-030 Per-instruction throughput is 2 cycles plus the time spent waiting for advance in ISSUE.

Reset
REQ-031 While rst=0, immediately and independently of clk:
  - state=IDLE;
  - instr=0, pc=0, valid=0, halted=0, icount=0.
REQ-032 Reset mid-operation (in any state) aborts the current instruction; memory contents are retained.
REQ-033 Reset release takes effect at the first rising clk edge after rst=1; outputs stay at reset values until then.
REQ-034 instr=0 after reset keeps the downstream control unit in its RESET state.

Verification
REQ-035 Load mem[0]=20'h4_1230, mem[1]=20'h8_0450, mem[2]=20'h0_0000; pulse start -> 2 cycles later valid=1, instr=20'h41230, pc=0.
REQ-036 Continuing REQ-035, pulse advance twice (one per ISSUE):
  - pc steps to 1 then 2, with instr=20'h80450 at pc=1;
  - at mem[2], halted=1 and icount=2;
  - further advance pulses leave pc and icount unchanged.
REQ-037 Fill all 32 words with 20'h40000 and hold advance=1:
  - pc wraps 31->0;
  - icount saturates at 255 and stays there.
REQ-038 In IDLE, assert load_en (addr 0, data 20'hC0010) and start in the same cycle -> first issued instr=20'hC0010.
REQ-039 Assert rst=0 while in ISSUE at pc=5:
  - all outputs zero asynchronously, with no wait for a clk edge;
  - after release and start, the memory words read back unchanged.
REQ-040 Assert load_en during ISSUE at address 3 -> mem[3] unchanged on a later fetch; assert start in HALT -> restarts at pc=0 with icount=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with an internal loadable instruction
// memory. It fetches one word at a time, presents it to a downstream control
// unit, and waits for that unit to consume it. A word whose top two bits are
// 2'b00 halts the sequence.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   load_en    memory write strobe (honoured in IDLE and HALT only)
//   load_addr  memory write address
//   load_data  memory write data
//   start      begin execution from address 0 (IDLE or HALT only)
//   advance    control unit consumed the current word (ISSUE only)
//   instr      registered instruction word
//   pc         address of the word on instr
//   valid      instr holds a fetched word
//   halted     a halt word is being held
//   icount     saturating count of words retired via advance
module instr_fetch #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   advance,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] icount
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] icount_q, icount_d;
  logic                   mem_we;
  logic                   is_halt_word;

  // Instruction storage; deliberately not reset so contents survive rst.
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // Halt opcode lives in the two most significant bits of the word.
  assign is_halt_word = (instr_q[INSTR_WIDTH-1 -: 2] == 2'b00);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    icount_d = icount_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_d  = '0;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        mem_we   = load_en;
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          icount_d = '0;
        end
      end

      // Registered read: the word lands on instr at the end of this cycle.
      ST_FETCH: begin
        instr_d = mem[pc_q];
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end

      // A halt word takes priority over advance.
      ST_ISSUE: begin
        if (is_halt_word) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (advance) begin
          pc_d    = pc_q + ADDR_BITS'(1);
          valid_d = 1'b0;
          state_d = ST_FETCH;
          if (icount_q != '1) begin
            icount_d = icount_q + COUNT_WIDTH'(1);
          end
        end
      end

      ST_HALT: begin
        halted_d = 1'b1;
        mem_we   = load_en;
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          icount_d = '0;
          halted_d = 1'b0;
          valid_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign valid  = valid_q;
  assign halted = halted_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Each issued word (rising valid) is
// compared against an expectation queue filled as stimulus is driven.
module tb_instr_fetch;

  localparam int unsigned IW = 20;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          advance = 1'b0;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;
  logic          valid;
  logic          halted;
  logic [CW-1:0] icount;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic [CW-1:0] icount;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic prev_valid = 1'b0;
  logic [IW-1:0] prog [7];

  instr_fetch #(
    .INSTR_WIDTH(IW),
    .ADDR_BITS  (AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start    (start),
    .advance  (advance),
    .instr    (instr),
    .pc       (pc),
    .valid    (valid),
    .halted   (halted),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input logic [IW-1:0] w, input int n);
    exp_t e;
    e.pc     = AW'(p);
    e.instr  = w;
    e.icount = CW'((n > 255) ? 255 : n);
    sb.push_back(e);
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 10; i++) begin
      if (valid === 1'b1) return;
      @(negedge clk);
    end
    chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic adv_issue();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    wait_issue();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_icount"}, 32'(icount), 32'd0);
  endtask

  // Scoreboard monitor: every new issue must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", 32'(instr), 32'(e.instr));
        chk("sb_pc", 32'(pc), 32'(e.pc));
        chk("sb_icount", 32'(icount), 32'(e.icount));
      end
    end
    prev_valid = valid;
  end

  initial begin
    prog[0] = 20'h41230; prog[1] = 20'h80450; prog[2] = 20'h40222;
    prog[3] = 20'h40333; prog[4] = 20'h40444; prog[5] = 20'h40555;
    prog[6] = 20'h00006;

    // Reset state
    #1 rst = 1'b0;
    #2 chk_zero("rst");
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b1;

    // Basic program: two words then a halt
    load(0, 20'h41230);
    load(1, 20'h80450);
    load(2, 20'h00000);
    push(0, 20'h41230, 0);
    push(1, 20'h80450, 1);
    push(2, 20'h00000, 2);
    start_pulse();
    chk("lat_fetch_valid", 32'(valid), 32'd0);
    @(negedge clk);
    chk("lat_issue_valid", 32'(valid), 32'd1);
    chk("first_instr", 32'(instr), 32'h41230);
    chk("first_pc", 32'(pc), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_instr", 32'(instr), 32'h41230);
    chk("hold_pc", 32'(pc), 32'd0);
    adv_issue();
    chk("pc1", 32'(pc), 32'd1);
    chk("instr1", 32'(instr), 32'h80450);
    adv_issue();
    @(negedge clk);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_icount", 32'(icount), 32'd2);
    repeat (3) begin
      advance = 1'b1;
      @(negedge clk);
    end
    advance = 1'b0;
    @(negedge clk);
    chk("halt_adv_pc", 32'(pc), 32'd2);
    chk("halt_adv_icount", 32'(icount), 32'd2);
    chk("halt_adv_valid", 32'(valid), 32'd1);

    // Load while halted, restart from HALT
    for (int i = 2; i < 7; i++) load(i, prog[i]);
    for (int i = 0; i < 6; i++) push(i, prog[i], i);
    start_pulse();
    wait_issue();
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_icount", 32'(icount), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    adv_issue();
    // Write attempt during ISSUE must be dropped
    load(3, 20'h4BAD3);
    repeat (4) adv_issue();
    chk("pc5", 32'(pc), 32'd5);

    // Asynchronous reset mid-ISSUE
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) push(i, prog[i], i);
    start_pulse();
    wait_issue();
    repeat (6) adv_issue();
    @(negedge clk);
    chk("run3_halted", 32'(halted), 32'd1);
    chk("run3_icount", 32'(icount), 32'd6);

    // Same-cycle load and start from IDLE
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(0, 20'hC0010, 0);
    load_en   = 1'b1;
    load_addr = '0;
    load_data = 20'hC0010;
    start     = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    wait_issue();
    chk("ld_start_instr", 32'(instr), 32'hC0010);

    // PC wrap and icount saturation with advance held
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) load(i, 20'h40000);
    for (int n = 0; n <= 300; n++) push(n % 32, 20'h40000, n);
    advance = 1'b1;
    start_pulse();
    begin : wrap_run
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk);
        #1;
        if (sb.size() == 1) begin
          reached = 1'b1;
          break;
        end
      end
      if (!reached) chk("wrap_timeout", 32'd0, 32'd1);
    end
    advance = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("sat_icount", 32'(icount), 32'd255);
    chk("wrap_pc", 32'(pc), 32'd12);
    repeat (3) @(negedge clk);
    chk("sat_hold_icount", 32'(icount), 32'd255);
    chk("sat_hold_pc", 32'(pc), 32'd12);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
